stream_player_chk: RTL and testbench
====================================

Name: stream_player_chk

Overview:
- Synthesizable stream source plus checker for stage-level regression of NN datapath blocks (float_24_8 style streams).
- Plays a loaded vector memory as a vld/rdy/fst stream with programmable frame length and repeat count.
- Simultaneously accepts the DUT result stream and compares it word-by-word against a loaded expected memory.
- Generalises the fixed-length, always-valid, free-running stimulus used today. Adds run control, repeats, backpressure-safe checking and error statistics.

Parameters:
- DATA_W, 32, stream word width (32 = float_24_8).
- DEPTH, 256, words per memory (stimulus and expected, each).
- ADDR_W, 8, index width; DEPTH <= 2**ADDR_W.
- CNT_W, 16, repeat-count and statistics width.
- LFSR_SEED, 16'hACE1, throttle LFSR seed (optional feature only).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ld_we  in  1  memory write enable
- ld_sel  in  1  write target: 0 = stimulus memory, 1 = expected memory
- ld_addr  in  ADDR_W  write address
- ld_data  in  DATA_W  write data
- cfg_len  in  ADDR_W+1  words per frame, 0..DEPTH
- cfg_reps  in  CNT_W  number of frames
- start  in  1  start pulse
- src_data  out  DATA_W  stimulus word
- src_fst  out  1  first word of frame
- src_vld  out  1  stimulus valid
- src_rdy  in  1  DUT accepts stimulus
- chk_data  in  DATA_W  DUT result word
- chk_fst  in  1  DUT result first flag
- chk_vld  in  1  DUT result valid
- chk_rdy  out  1  checker ready
- busy  out  1  state == RUN
- done  out  1  state == DONE
- err_count  out  CNT_W  mismatch count, saturating
- first_err_idx  out  CNT_W  global index of first mismatch
- err_seen  out  1  at least one mismatch since start

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state IDLE; all counters 0. src_vld, src_fst, chk_rdy, busy, done, err_seen = 0. err_count = 0, first_err_idx = 0, src_data = 0. Memories are not reset.
- Memory writes:
  - Accepted only when not busy; ld_we during RUN is ignored.
  - Write-then-read of the same address is visible the next cycle.
- FSM IDLE/RUN/DONE:
  - IDLE/DONE + start: if cfg_len == 0 or cfg_reps == 0, go to DONE with zero transfers. Otherwise go to RUN.
  - Entering RUN latches cfg_len/cfg_reps and clears all counters and statistics. cfg changes mid-run have no effect.
  - RUN -> DONE in the cycle after both source and checker have completed cfg_len*cfg_reps transfers.
  - start during RUN is ignored.
  - Reset mid-run returns to IDLE immediately; no partial done.
- Source:
  - Combinational read: src_data = stim_mem[src_idx] while src_vld, else 0.
  - src_fst = src_vld & (src_idx == 0).
  - Transfer is src_vld & src_rdy. src_idx advances on each transfer and wraps len-1 -> 0, incrementing src_frame.
  - src_vld stays high in RUN until src_frame == reps, then drops the cycle after the final transfer.
  - Zero added latency: the first word is valid in the first RUN cycle.
- Checker:
  - chk_rdy is high in RUN until the checker has received len*reps words. Words offered after that are not accepted.
  - On chk_vld & chk_rdy, a mismatch is flagged if chk_data != exp_mem[chk_idx] or chk_fst != (chk_idx == 0).
  - chk_idx wraps like src_idx.
  - Global index chk_gidx increments per accepted word (CNT_W bits, wraps silently).
  - On a mismatch: err_count increments, saturating at all ones. On the first mismatch only, err_seen is set and first_err_idx = chk_gidx.
- Simultaneous events: source and checker transfers in the same cycle are independent. The final source and final checker transfer in the same cycle give DONE the next cycle.
- Status: busy and done are registered state decodes. Statistics hold in DONE until the next start.

Optional Feature:
- Macro: STREAM_PLAYER_THROTTLE_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) is seeded with LFSR_SEED at reset and start, and steps every cycle.
  - A new src_vld may only rise when lfsr[0] == 1. Once raised, src_vld holds until transfer (AXI-style stability).
  - chk_rdy is additionally gated by lfsr[1].
  - Throttling never changes data order or results.
- Undefined: no LFSR; src_vld and chk_rdy follow the rules above without gating.

Test Plan:
- Basic run: load stim[i] = i, exp[i] = i, len = 36, reps = 1, tie chk to src, src_rdy = 1 -> 36 transfers, src_fst only on word 0, done 1 cycle after last, err_count = 0.
- Repeats: len = 4, reps = 3, loopback -> src_data sequence 0,1,2,3 ×3, fst on global words 0/4/8, done after 12, err_seen = 0.
- Backpressure: src_rdy toggling 1,0,0,1 -> src_data/src_fst stable while stalled, no word dropped or duplicated, err_count = 0.
- Mismatch: corrupt exp[5] and exp[9], len = 16, reps = 2 -> err_count = 4, first_err_idx = 5, err_seen = 1.
- Edge cases: cfg_len = 0 + start -> DONE next cycle with no src_vld. Reset asserted at word 10 -> IDLE next cycle, all outputs at reset values. Restart works.
- Throttle (STREAM_PLAYER_THROTTLE_EN): len = 36, reps = 2 -> same output sequence as unthrottled, src_vld never drops without a transfer, err_count = 0.

Source files
------------

// File: rtl/stream_player_chk.sv
// Stream source plus result checker: replays a stimulus memory as a vld/rdy/fst stream
// and compares the returned stream against an expected memory. Optional LFSR throttle: STREAM_PLAYER_THROTTLE_EN.
module stream_player_chk #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
`ifdef STREAM_PLAYER_THROTTLE_EN
  ,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_we,
  input  logic              ld_sel,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [CNT_W-1:0]  cfg_reps,
  input  logic              start,
  output logic [DATA_W-1:0] src_data,
  output logic              src_fst,
  output logic              src_vld,
  input  logic              src_rdy,
  input  logic [DATA_W-1:0] chk_data,
  input  logic              chk_fst,
  input  logic              chk_vld,
  output logic              chk_rdy,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic              err_seen
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [DATA_W-1:0] stim_mem_q [DEPTH];
  logic [DATA_W-1:0] exp_mem_q  [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [CNT_W-1:0]  reps_q, reps_d;
  logic [ADDR_W-1:0] src_idx_q, src_idx_d;
  logic [CNT_W-1:0]  src_frame_q, src_frame_d;
  logic              src_vld_q, src_vld_d;
  logic [ADDR_W-1:0] chk_idx_q, chk_idx_d;
  logic [CNT_W-1:0]  chk_frame_q, chk_frame_d;
  logic [CNT_W-1:0]  chk_gidx_q, chk_gidx_d;
  logic              chk_rdy_q, chk_rdy_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic [CNT_W-1:0]  first_err_idx_q, first_err_idx_d;
  logic              err_seen_q, err_seen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              start_s;
  logic              src_xfer_s, chk_xfer_s;
  logic              src_last_s, chk_last_s;
  logic              src_more_s, chk_more_s;
  logic              mismatch_s;
  logic              gate_src_s, gate_chk_s;

`ifdef STREAM_PLAYER_THROTTLE_EN
  logic [15:0]       lfsr_q, lfsr_d;
  logic              lfsr_fb_s;
`endif

  // Memory load port; the memories are frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (ld_we && (state_q != ST_RUN)) begin
      if (ld_sel) begin
        exp_mem_q[ld_addr] <= ld_data;
      end else begin
        stim_mem_q[ld_addr] <= ld_data;
      end
    end
  end

  // Next-state computation for the run FSM, both stream sides and the statistics.
  always_comb begin
    start_s    = start && (state_q != ST_RUN);
    src_xfer_s = src_vld_q && src_rdy;
    chk_xfer_s = chk_rdy_q && chk_vld;
    src_last_s = ({1'b0, src_idx_q} == (len_q - (ADDR_W+1)'(1)));
    chk_last_s = ({1'b0, chk_idx_q} == (len_q - (ADDR_W+1)'(1)));
    mismatch_s = (chk_data != exp_mem_q[chk_idx_q]) ||
                 (chk_fst != (chk_idx_q == {ADDR_W{1'b0}}));

`ifdef STREAM_PLAYER_THROTTLE_EN
    lfsr_fb_s = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    if (start_s) begin
      lfsr_d = LFSR_SEED;
    end else begin
      lfsr_d = {lfsr_q[14:0], lfsr_fb_s};
    end
    // Gates use the LFSR value that will be live while the new flag is visible.
    gate_src_s = lfsr_d[0];
    gate_chk_s = lfsr_d[1];
`else
    gate_src_s = 1'b1;
    gate_chk_s = 1'b1;
`endif

    state_d         = state_q;
    len_d           = len_q;
    reps_d          = reps_q;
    src_idx_d       = src_idx_q;
    src_frame_d     = src_frame_q;
    src_vld_d       = src_vld_q;
    chk_idx_d       = chk_idx_q;
    chk_frame_d     = chk_frame_q;
    chk_gidx_d      = chk_gidx_q;
    chk_rdy_d       = chk_rdy_q;
    err_count_d     = err_count_q;
    first_err_idx_d = first_err_idx_q;
    err_seen_d      = err_seen_q;
    src_more_s      = 1'b0;
    chk_more_s      = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_s) begin
          src_idx_d       = {ADDR_W{1'b0}};
          src_frame_d     = {CNT_W{1'b0}};
          chk_idx_d       = {ADDR_W{1'b0}};
          chk_frame_d     = {CNT_W{1'b0}};
          chk_gidx_d      = {CNT_W{1'b0}};
          err_count_d     = {CNT_W{1'b0}};
          first_err_idx_d = {CNT_W{1'b0}};
          err_seen_d      = 1'b0;
          if ((cfg_len == {(ADDR_W+1){1'b0}}) || (cfg_reps == {CNT_W{1'b0}})) begin
            state_d   = ST_DONE;
            src_vld_d = 1'b0;
            chk_rdy_d = 1'b0;
          end else begin
            state_d   = ST_RUN;
            len_d     = cfg_len;
            reps_d    = cfg_reps;
            src_vld_d = gate_src_s;
            chk_rdy_d = gate_chk_s;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (src_xfer_s) begin
          if (src_last_s) begin
            src_idx_d   = {ADDR_W{1'b0}};
            src_frame_d = src_frame_q + CNT_W'(1);
          end else begin
            src_idx_d   = src_idx_q + ADDR_W'(1);
          end
        end else begin
          src_idx_d = src_idx_q;
        end

        if (chk_xfer_s) begin
          chk_gidx_d = chk_gidx_q + CNT_W'(1);
          if (chk_last_s) begin
            chk_idx_d   = {ADDR_W{1'b0}};
            chk_frame_d = chk_frame_q + CNT_W'(1);
          end else begin
            chk_idx_d   = chk_idx_q + ADDR_W'(1);
          end
          if (mismatch_s) begin
            if (err_count_q != {CNT_W{1'b1}}) begin
              err_count_d = err_count_q + CNT_W'(1);
            end else begin
              err_count_d = err_count_q;
            end
            if (!err_seen_q) begin
              err_seen_d      = 1'b1;
              first_err_idx_d = chk_gidx_q;
            end else begin
              err_seen_d = 1'b1;
            end
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          chk_gidx_d = chk_gidx_q;
        end

        src_more_s = (src_frame_d != reps_q);
        chk_more_s = (chk_frame_d != reps_q);
        // An offered word is held until it transfers; only a fresh offer waits on the gate.
        src_vld_d  = (src_vld_q && !src_xfer_s) || (src_more_s && gate_src_s);
        chk_rdy_d  = chk_more_s && gate_chk_s;

        if (!src_more_s && !chk_more_s) begin
          state_d   = ST_DONE;
          src_vld_d = 1'b0;
          chk_rdy_d = 1'b0;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        src_vld_d = 1'b0;
        chk_rdy_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, counters, statistics and registered status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      len_q           <= {(ADDR_W+1){1'b0}};
      reps_q          <= {CNT_W{1'b0}};
      src_idx_q       <= {ADDR_W{1'b0}};
      src_frame_q     <= {CNT_W{1'b0}};
      src_vld_q       <= 1'b0;
      chk_idx_q       <= {ADDR_W{1'b0}};
      chk_frame_q     <= {CNT_W{1'b0}};
      chk_gidx_q      <= {CNT_W{1'b0}};
      chk_rdy_q       <= 1'b0;
      err_count_q     <= {CNT_W{1'b0}};
      first_err_idx_q <= {CNT_W{1'b0}};
      err_seen_q      <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
`ifdef STREAM_PLAYER_THROTTLE_EN
      lfsr_q          <= LFSR_SEED;
`endif
    end else begin
      state_q         <= state_d;
      len_q           <= len_d;
      reps_q          <= reps_d;
      src_idx_q       <= src_idx_d;
      src_frame_q     <= src_frame_d;
      src_vld_q       <= src_vld_d;
      chk_idx_q       <= chk_idx_d;
      chk_frame_q     <= chk_frame_d;
      chk_gidx_q      <= chk_gidx_d;
      chk_rdy_q       <= chk_rdy_d;
      err_count_q     <= err_count_d;
      first_err_idx_q <= first_err_idx_d;
      err_seen_q      <= err_seen_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
`ifdef STREAM_PLAYER_THROTTLE_EN
      lfsr_q          <= lfsr_d;
`endif
    end
  end

  assign src_data      = src_vld_q ? stim_mem_q[src_idx_q] : {DATA_W{1'b0}};
  assign src_fst       = src_vld_q && (src_idx_q == {ADDR_W{1'b0}});
  assign src_vld       = src_vld_q;
  assign chk_rdy       = chk_rdy_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_idx_q;
  assign err_seen      = err_seen_q;

endmodule

// File: tb/tb_stream_player_chk.sv
// Bench for stream_player_chk: directed vector table, hand-written corner sequences and
// randomized runs checked against an index-arithmetic model of the expected streams.
module tb_stream_player_chk;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_we;
  logic              ld_sel;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [ADDR_W:0]   cfg_len;
  logic [CNT_W-1:0]  cfg_reps;
  logic              start;
  logic [DATA_W-1:0] src_data;
  logic              src_fst;
  logic              src_vld;
  logic              src_rdy;
  logic [DATA_W-1:0] chk_data;
  logic              chk_fst;
  logic              chk_vld;
  logic              chk_rdy;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic [CNT_W-1:0]  first_err_idx;
  logic              err_seen;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DATA_W-1:0] stim_m [DEPTH];
  logic [DATA_W-1:0] exp_m  [DEPTH];

  typedef struct {
    string nm;
    int    len;
    int    reps;
    int    rdy_pct;
    int    vld_pct;
    int    flip_g;
    int    corrupt;
    int    req_err;
    int    req_first;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  stream_player_chk #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
    .cfg_len(cfg_len), .cfg_reps(cfg_reps), .start(start),
    .src_data(src_data), .src_fst(src_fst), .src_vld(src_vld), .src_rdy(src_rdy),
    .chk_data(chk_data), .chk_fst(chk_fst), .chk_vld(chk_vld), .chk_rdy(chk_rdy),
    .busy(busy), .done(done), .err_count(err_count),
    .first_err_idx(first_err_idx), .err_seen(err_seen)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pick(input int pct, input int cyc);
    if (pct < 0) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic write_mems(input int n);
    for (int i = 0; i < n; i++) begin
      ld_we = 1'b1; ld_sel = 1'b0; ld_addr = ADDR_W'(i); ld_data = stim_m[i];
      tick();
      ld_sel = 1'b1; ld_data = exp_m[i];
      tick();
    end
    ld_we = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, " flags"}, {58'd0, busy, done, src_vld, src_fst, chk_rdy, err_seen}, 64'd0);
    check({nm, " src_data"}, 64'(src_data), 64'd0);
    check({nm, " err_count"}, 64'(err_count), 64'd0);
    check({nm, " first_err_idx"}, 64'(first_err_idx), 64'd0);
  endtask

  // One complete run; req_err < 0 means the expected statistics come from the model.
  task automatic run_case(input string nm, input int len, input int reps, input int rdy_pct,
                          input int vld_pct, input int flip_g, input int req_err, input int req_first);
    int total, m_err, m_first, nsrc, nchk, cyc, bound, idx;
    int bad_seq, bad_stab, bad_gap, bad_over, timed_out;
    logic xs, xc, prev_stall, prev_fst, first_cyc;
    logic [DATA_W-1:0] prev_data;

    total = len * reps;
    m_err = 0; m_first = 0;
    for (int g = 0; g < total; g++) begin
      if ((stim_m[g % len] != exp_m[g % len]) || (g == flip_g)) begin
        if (m_err == 0) m_first = g;
        m_err++;
      end
    end
    if (req_err >= 0) begin
      m_err = req_err; m_first = req_first;
    end

    cfg_len = (ADDR_W+1)'(len); cfg_reps = CNT_W'(reps); start = 1'b1;
    src_rdy = 1'b0; chk_vld = 1'b0;
    tick();
    start = 1'b0;
    cfg_len = (ADDR_W+1)'($urandom_range(0, 300));
    cfg_reps = CNT_W'($urandom);

    nsrc = 0; nchk = 0; cyc = 0; bound = total * 30 + 50;
    bad_seq = 0; bad_stab = 0; bad_gap = 0; bad_over = 0; timed_out = 0;
    prev_stall = 1'b0; prev_fst = 1'b0; prev_data = '0; first_cyc = 1'b1;
    src_rdy = pick(rdy_pct, cyc); chk_vld = pick(vld_pct, cyc);
    chk_data = stim_m[0]; chk_fst = 1'b1 ^ (flip_g == 0);

    while (1) begin
      @(negedge clk);
      if (first_cyc) begin
        check({nm, " busy_first"}, 64'(busy), 64'd1);
`ifndef STREAM_PLAYER_THROTTLE_EN
        check({nm, " vld_first"}, 64'(src_vld), 64'd1);
`endif
        first_cyc = 1'b0;
      end
      if ((nsrc == total) && (nchk == total)) break;
      if (!busy || (cyc > bound)) begin
        timed_out = 1;
        break;
      end
      if (src_vld) begin
        idx = nsrc % len;
        if ((nsrc >= total) || (src_data != stim_m[idx]) || (src_fst != (idx == 0))) bad_seq++;
      end else begin
        if (src_data != '0) bad_seq++;
`ifndef STREAM_PLAYER_THROTTLE_EN
        if (nsrc < total) bad_gap++;
`endif
      end
      if (prev_stall && (!src_vld || (src_data != prev_data) || (src_fst != prev_fst))) bad_stab++;
      if (chk_rdy && (nchk >= total)) bad_over++;
      xs = src_vld && src_rdy;
      xc = chk_vld && chk_rdy;
      prev_stall = src_vld && !src_rdy;
      prev_data = src_data;
      prev_fst = src_fst;

      tick();
      cyc++;
      if (xs) nsrc++;
      if (xc) nchk++;
      src_rdy = pick(rdy_pct, cyc);
      chk_vld = pick(vld_pct, cyc);
      chk_data = stim_m[nchk % len];
      chk_fst = ((nchk % len) == 0) ^ (nchk == flip_g);
    end

    check({nm, " timeout"}, 64'(timed_out), 64'd0);
    check({nm, " src_seq"}, 64'(bad_seq), 64'd0);
    check({nm, " src_stable"}, 64'(bad_stab), 64'd0);
    check({nm, " src_gap"}, 64'(bad_gap), 64'd0);
    check({nm, " chk_overrun"}, 64'(bad_over), 64'd0);
    check({nm, " done"}, {62'd0, done, busy}, 64'd2);
    check({nm, " idle_streams"}, {62'd0, src_vld, chk_rdy}, 64'd0);
    check({nm, " err_count"}, 64'(err_count), 64'(m_err));
    check({nm, " first_err_idx"}, 64'(first_err_idx), 64'(m_first));
    check({nm, " err_seen"}, 64'(err_seen), 64'(m_err != 0));
    src_rdy = 1'b0; chk_vld = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ld_we = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    cfg_len = '0; cfg_reps = '0; start = 1'b0; src_rdy = 1'b0;
    chk_data = '0; chk_fst = 1'b0; chk_vld = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset");
    tick();

    vecs[0] = '{"basic",    36, 1, 100, 100, -1, 0, 0, 0};
    vecs[1] = '{"repeats",   4, 3, 100, 100, -1, 0, 0, 0};
    vecs[2] = '{"bp_1001",   8, 2,  -1, 100, -1, 0, 0, 0};
    vecs[3] = '{"mismatch", 16, 2,  70,  80, -1, 1, 4, 5};
    vecs[4] = '{"fst_flip", 10, 3,  60,  50, 13, 0, 1, 13};
    vecs[5] = '{"full",    256, 1,  90,  90, -1, 0, 0, 0};
    vecs[6] = '{"len1",      1, 5,  50,  50, -1, 0, 0, 0};

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].len; i++) begin
        stim_m[i] = DATA_W'(i);
        exp_m[i]  = DATA_W'(i);
      end
      if (vecs[v].corrupt != 0) begin
        exp_m[5] = exp_m[5] ^ 32'h0000_0001;
        exp_m[9] = exp_m[9] ^ 32'h8000_0000;
      end
      write_mems(vecs[v].len);
      run_case(vecs[v].nm, vecs[v].len, vecs[v].reps, vecs[v].rdy_pct, vecs[v].vld_pct,
               vecs[v].flip_g, vecs[v].req_err, vecs[v].req_first);
      tick();
    end

    // Zero-length and zero-repeat starts finish immediately without offering data.
    cfg_len = 9'd0; cfg_reps = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("len0 state", {61'd0, done, busy, src_vld}, 64'd4);
    tick();
    cfg_len = 9'd5; cfg_reps = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("reps0 state", {61'd0, done, busy, src_vld}, 64'd4);
    tick();

    // Loads and starts during RUN are ignored.
    stim_m[0] = 32'h1234_5678; exp_m[0] = 32'h1234_5678;
    write_mems(1);
    cfg_len = 9'd4; cfg_reps = 16'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = 8'd0; ld_data = 32'hFFFF_0000;
    cfg_len = 9'd0; start = 1'b1;
    tick();
    ld_we = 1'b0; start = 1'b0;
    tick();
    @(negedge clk);
    check("run_ignore busy", 64'(busy), 64'd1);
    check("run_ignore data", 64'(src_data), 64'h1234_5678);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Reset in the middle of a run, with errors already counted.
    for (int i = 0; i < 36; i++) begin
      stim_m[i] = DATA_W'(i); exp_m[i] = DATA_W'(i);
    end
    write_mems(36);
    cfg_len = 9'd36; cfg_reps = 16'd1; start = 1'b1;
    tick();
    start = 1'b0; src_rdy = 1'b1; chk_vld = 1'b1; chk_data = 32'hDEAD_BEEF; chk_fst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    @(negedge clk);
    check("pre_reset err_seen", 64'(err_seen), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; src_rdy = 1'b0; chk_vld = 1'b0;
    @(negedge clk);
    check_idle("mid_reset");
    tick();
    run_case("restart", 36, 1, 100, 100, -1, -1, 0);
    tick();

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      int len, reps, flip;
      len = $urandom_range(1, 40);
      reps = $urandom_range(1, 4);
      for (int i = 0; i < len; i++) begin
        stim_m[i] = $urandom;
        exp_m[i]  = stim_m[i];
      end
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        int a;
        a = $urandom_range(0, len - 1);
        exp_m[a] = exp_m[a] ^ (32'h1 << $urandom_range(0, 31));
      end
      flip = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, len * reps - 1)) : -1;
      write_mems(len);
      run_case($sformatf("rand%0d", r), len, reps, $urandom_range(30, 100),
               $urandom_range(30, 100), flip, -1, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
